// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: next-PC decode inputs, instruction-memory handshake and IF/ID outputs.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
);
  logic [1:0]         next_instr_sel;
  logic               sel_valid;
  logic [ADDR_W-1:0]  jump_target;
  logic [ADDR_W-1:0]  branch_target;
  logic               stall;
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;
  logic               if_id_valid;
  logic [INSTR_W-1:0] if_id_instr;
  logic [ADDR_W-1:0]  if_id_pc;
  logic [ADDR_W-1:0]  if_id_pc4;

  modport master (
    input  next_instr_sel, sel_valid, jump_target, branch_target, stall,
    input  imem_rdata, imem_ack,
    output imem_req, imem_addr,
    output if_id_valid, if_id_instr, if_id_pc, if_id_pc4
  );

  modport slave (
    output next_instr_sel, sel_valid, jump_target, branch_target, stall,
    output imem_rdata, imem_ack,
    input  imem_req, imem_addr,
    input  if_id_valid, if_id_instr, if_id_pc, if_id_pc4
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the imem handshake and fills IF/ID,
// with a one-entry skid for stalls and a kill state that drains a redirected request.
module fetch_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic          clk,
  input logic          rst_n,
  fetch_unit_if.master fu
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HOLD  = 2'd1,
    ST_KILL  = 2'd2
  } state_e;

  state_e             state_q;
  logic [ADDR_W-1:0]  req_addr_q;
  logic [ADDR_W-1:0]  kill_target_q;
  logic [INSTR_W-1:0] skid_instr_q;
  logic [ADDR_W-1:0]  skid_pc_q;
  logic               if_id_valid_q;
  logic [INSTR_W-1:0] if_id_instr_q;
  logic [ADDR_W-1:0]  if_id_pc_q;
  logic [ADDR_W-1:0]  if_id_pc4_q;

  logic               redirect_c;
  logic [ADDR_W-1:0]  target_c;
  logic [ADDR_W-1:0]  req_addr_inc_c;

  // Codes 01 and 11 redirect; both have bit 0 set, bit 1 picks the branch target.
  assign redirect_c     = fu.sel_valid & fu.next_instr_sel[0];
  assign target_c       = fu.next_instr_sel[1] ? fu.branch_target : fu.jump_target;
  assign req_addr_inc_c = req_addr_q + STEP;

  assign fu.imem_req    = rst_n & (state_q != ST_HOLD);
  assign fu.imem_addr   = req_addr_q;
  assign fu.if_id_valid = if_id_valid_q;
  assign fu.if_id_instr = if_id_instr_q;
  assign fu.if_id_pc    = if_id_pc_q;
  assign fu.if_id_pc4   = if_id_pc4_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_FETCH;
      req_addr_q    <= RESET_PC;
      kill_target_q <= '0;
      skid_instr_q  <= '0;
      skid_pc_q     <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (redirect_c) begin
            if_id_valid_q <= 1'b0;
            if (fu.imem_ack) begin
              req_addr_q <= target_c;
            end else begin
              kill_target_q <= target_c;
              state_q       <= ST_KILL;
            end
          end else if (fu.imem_ack) begin
            req_addr_q <= req_addr_inc_c;
            if (fu.stall) begin
              skid_instr_q <= fu.imem_rdata;
              skid_pc_q    <= req_addr_q;
              state_q      <= ST_HOLD;
            end else begin
              if_id_valid_q <= 1'b1;
              if_id_instr_q <= fu.imem_rdata;
              if_id_pc_q    <= req_addr_q;
              if_id_pc4_q   <= req_addr_inc_c;
            end
          end else if (!fu.stall) begin
            if_id_valid_q <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (redirect_c) begin
            if_id_valid_q <= 1'b0;
            req_addr_q    <= target_c;
            state_q       <= ST_FETCH;
          end else if (!fu.stall) begin
            if_id_valid_q <= 1'b1;
            if_id_instr_q <= skid_instr_q;
            if_id_pc_q    <= skid_pc_q;
            if_id_pc4_q   <= skid_pc_q + STEP;
            state_q       <= ST_FETCH;
          end
        end

        ST_KILL: begin
          // Old request stays on the bus until acked; its data is dropped.
          if (fu.imem_ack) begin
            req_addr_q <= redirect_c ? target_c : kill_target_q;
            state_q    <= ST_FETCH;
          end else if (redirect_c) begin
            kill_target_q <= target_c;
          end
        end

        default: begin
          state_q       <= ST_FETCH;
          if_id_valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table followed by randomized traffic against a reference model.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .fu    (bus)
  );

  typedef struct {
    logic        rst_n;
    logic        sv;
    logic [1:0]  sel;
    logic [31:0] tgt;
    logic        stall;
    logic        ack;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  function automatic logic [31:0] ins(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  function automatic vec_t mk(input logic r, input logic sv, input logic [1:0] sel,
                              input logic [31:0] tgt, input logic st, input logic ack,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic evld, input logic [31:0] epc);
    vec_t v;
    v.rst_n = r; v.sv = sv; v.sel = sel; v.tgt = tgt; v.stall = st; v.ack = ack;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_valid = evld; v.exp_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state: fetch pointer, pending-kill target, held entry, IF/ID image.
  logic [31:0] m_addr, m_ktgt, m_instr, m_pc, m_pc4;
  logic        m_valid, m_kill, m_rst_now;
  entry_t      m_held[$];

  task automatic model_step(input logic r, input logic sv, input logic [1:0] sel,
                            input logic [31:0] jt, input logic [31:0] bt,
                            input logic st, input logic ack, input logic [31:0] rd);
    logic        redir;
    logic [31:0] tgt;
    entry_t      e;
    redir = sv && (sel == 2'b01 || sel == 2'b11);
    tgt   = (sel == 2'b01) ? jt : bt;
    if (!r) begin
      m_addr = 32'h0; m_ktgt = 32'h0; m_kill = 1'b0; m_held.delete();
      m_valid = 1'b0; m_instr = 32'h0; m_pc = 32'h0; m_pc4 = 32'h0;
    end else if (m_kill) begin
      if (ack) begin
        m_addr = redir ? tgt : m_ktgt;
        m_kill = 1'b0;
      end else if (redir) begin
        m_ktgt = tgt;
      end
    end else if (m_held.size() != 0) begin
      if (redir) begin
        m_held.delete(); m_valid = 1'b0; m_addr = tgt;
      end else if (!st) begin
        e = m_held.pop_front();
        m_valid = 1'b1; m_instr = e.instr; m_pc = e.pc; m_pc4 = e.pc + 32'd4;
      end
    end else begin
      if (redir) begin
        m_valid = 1'b0;
        if (ack) m_addr = tgt;
        else begin m_kill = 1'b1; m_ktgt = tgt; end
      end else if (ack) begin
        e.instr = rd; e.pc = m_addr;
        m_addr = m_addr + 32'd4;
        if (st) m_held.push_back(e);
        else begin m_valid = 1'b1; m_instr = e.instr; m_pc = e.pc; m_pc4 = e.pc + 32'd4; end
      end else if (!st) begin
        m_valid = 1'b0;
      end
    end
  endtask

  vec_t vt[21];

  initial begin
    bus.next_instr_sel = 2'b00;
    bus.sel_valid      = 1'b0;
    bus.jump_target    = 32'h0;
    bus.branch_target  = 32'h0;
    bus.stall          = 1'b0;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = 32'h0;

    vt[0]  = mk(0,0,2'b00,32'h0,       0,0, 0,32'h0,       0,32'h0);
    vt[1]  = mk(1,0,2'b00,32'h0,       0,1, 1,32'h4,       1,32'h0);
    vt[2]  = mk(1,0,2'b00,32'h0,       0,1, 1,32'h8,       1,32'h4);
    vt[3]  = mk(1,1,2'b01,32'h100,     0,1, 1,32'h100,     0,32'h4);
    vt[4]  = mk(1,0,2'b00,32'h0,       0,1, 1,32'h104,     1,32'h100);
    vt[5]  = mk(1,1,2'b10,32'h300,     0,1, 1,32'h108,     1,32'h104);
    vt[6]  = mk(1,0,2'b11,32'h40,      0,1, 1,32'h10C,     1,32'h108);
    vt[7]  = mk(1,0,2'b00,32'h0,       1,1, 0,32'h110,     1,32'h108);
    vt[8]  = mk(1,0,2'b00,32'h0,       1,0, 0,32'h110,     1,32'h108);
    vt[9]  = mk(1,0,2'b00,32'h0,       0,0, 1,32'h110,     1,32'h10C);
    vt[10] = mk(1,0,2'b00,32'h0,       0,0, 1,32'h110,     0,32'h10C);
    vt[11] = mk(1,0,2'b00,32'h0,       1,0, 1,32'h110,     0,32'h10C);
    vt[12] = mk(1,1,2'b11,32'h40,      0,0, 1,32'h110,     0,32'h10C);
    vt[13] = mk(1,1,2'b01,32'h80,      0,0, 1,32'h110,     0,32'h10C);
    vt[14] = mk(1,0,2'b00,32'h0,       0,1, 1,32'h80,      0,32'h10C);
    vt[15] = mk(1,0,2'b00,32'h0,       0,1, 1,32'h84,      1,32'h80);
    vt[16] = mk(1,1,2'b01,32'hFFFFFFFC,0,1, 1,32'hFFFFFFFC,0,32'h80);
    vt[17] = mk(1,0,2'b00,32'h0,       0,1, 1,32'h0,       1,32'hFFFFFFFC);
    vt[18] = mk(1,1,2'b01,32'h200,     0,0, 1,32'h0,       0,32'hFFFFFFFC);
    vt[19] = mk(0,0,2'b00,32'h0,       0,1, 0,32'h0,       0,32'h0);
    vt[20] = mk(1,0,2'b00,32'h0,       0,1, 1,32'h4,       1,32'h0);

    // Directed vectors: inputs held for one cycle, outputs checked just after the edge.
    for (int i = 0; i < 21; i++) begin
      rst_n              = vt[i].rst_n;
      bus.sel_valid      = vt[i].sv;
      bus.next_instr_sel = vt[i].sel;
      bus.jump_target    = (vt[i].sel == 2'b01) ? vt[i].tgt : vt[i].tgt + 32'h1000;
      bus.branch_target  = (vt[i].sel == 2'b11) ? vt[i].tgt : vt[i].tgt + 32'h2000;
      bus.stall          = vt[i].stall;
      bus.imem_ack       = vt[i].ack;
      bus.imem_rdata     = ins(bus.imem_addr);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.req", i),   32'(bus.imem_req),    32'(vt[i].exp_req));
      chk($sformatf("v%0d.addr", i),  bus.imem_addr,        vt[i].exp_addr);
      chk($sformatf("v%0d.valid", i), 32'(bus.if_id_valid), 32'(vt[i].exp_valid));
      chk($sformatf("v%0d.pc", i),    bus.if_id_pc,         vt[i].exp_pc);
      if (vt[i].exp_valid) begin
        chk($sformatf("v%0d.instr", i), bus.if_id_instr, ins(vt[i].exp_pc));
        chk($sformatf("v%0d.pc4", i),   bus.if_id_pc4,   vt[i].exp_pc + 32'd4);
      end
      if (!vt[i].rst_n) begin
        chk($sformatf("v%0d.rst_instr", i), bus.if_id_instr, 32'h0);
        chk($sformatf("v%0d.rst_pc4", i),   bus.if_id_pc4,   32'h0);
      end
    end

    // Randomized traffic; first cycle forces reset to align the model.
    m_rst_now = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      logic        r, sv, st, ack;
      logic [1:0]  sel;
      logic [31:0] jt, bt, rd;
      if (i > 0) begin
        chk("rnd.req",   32'(bus.imem_req), 32'(m_rst_now && m_held.size() == 0));
        chk("rnd.addr",  bus.imem_addr,     m_addr);
        chk("rnd.valid", 32'(bus.if_id_valid), 32'(m_valid));
        chk("rnd.pc",    bus.if_id_pc,      m_pc);
        chk("rnd.pc4",   bus.if_id_pc4,     m_pc4);
        chk("rnd.instr", bus.if_id_instr,   m_instr);
      end
      r   = (i == 0) ? 1'b0 : ($urandom_range(99) != 0);
      sv  = ($urandom_range(3) == 0);
      sel = 2'($urandom_range(3));
      jt  = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      bt  = $urandom & 32'hFFFF_FFFC;
      st  = ($urandom_range(3) == 0);
      ack = ($urandom_range(9) < 6);
      rd  = ack ? ins(bus.imem_addr) : $urandom;
      rst_n              = r;
      bus.sel_valid      = sv;
      bus.next_instr_sel = sel;
      bus.jump_target    = jt;
      bus.branch_target  = bt;
      bus.stall          = st;
      bus.imem_ack       = ack;
      bus.imem_rdata     = rd;
      model_step(r, sv, sel, jt, bt, st, ack, rd);
      m_rst_now = r;
      @(posedge clk);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage directly downstream of the next-PC decoder: consumes its 2-bit `NextInstrSel` code together with the jump and branch targets, owns the program counter, drives the instruction-memory request handshake and fills the IF/ID pipeline register. It supports variable-latency memory, stalls from the hazard unit, and control-flow redirects that flush the fetched instruction and discard in-flight responses.

## Interface
- `ADDR_W`, 32, PC/address width
- `INSTR_W`, 32, instruction width
- `RESET_PC`, 0, first fetch address after reset

- `clk`  in  1  clock, all state updates on rising edge
- `rst_n`  in  1  synchronous reset, active-low
- `next_instr_sel`  in  2  decoder code: 00 sequential, 01 jump, 11 branch taken, 10 treated as sequential
- `sel_valid`  in  1  `next_instr_sel` belongs to a valid resolving instruction this cycle
- `jump_target`  in  ADDR_W  target for code 01 (immediate or register jump)
- `branch_target`  in  ADDR_W  target for code 11
- `stall`  in  1  hazard unit: hold IF/ID contents
- `imem_req`  out  1  fetch request
- `imem_addr`  out  ADDR_W  fetch address, stable while `imem_req` high until ack
- `imem_rdata`  in  INSTR_W  instruction, valid when `imem_ack`
- `imem_ack`  in  1  response; sampled only while `imem_req` high; may arrive same cycle as request
- `if_id_valid`  out  1  IF/ID holds a live instruction
- `if_id_instr`  out  INSTR_W  fetched instruction
- `if_id_pc`  out  ADDR_W  its address
- `if_id_pc4`  out  ADDR_W  its address + 4

## Operation
- redirect = `sel_valid` & (sel == 01 | sel == 11); target = sel 01 ? `jump_target` : `branch_target`. Codes 00/10 or `sel_valid`=0: no redirect.
- Registers: `req_addr` (drives `imem_addr`), `kill_target`, skid {instr, pc}, IF/ID, state.
- `imem_req` = `rst_n` & (state == FETCH | KILL).
- State FETCH:
  - redirect (highest priority, overrides `stall`): `if_id_valid`<=0; if ack, response discarded, `req_addr`<=target, stay; else `kill_target`<=target, go KILL.
  - ack & !stall: IF/ID <= {rdata, req_addr, req_addr+4}, valid 1; `req_addr`+=4.
  - ack & stall: skid <= {rdata, req_addr}; `req_addr`+=4; go HOLD; IF/ID unchanged.
  - !ack & stall: no change. !ack & !stall: `if_id_valid`<=0 (bubble).
- State HOLD (no request): redirect → `if_id_valid`<=0, skid dropped, `req_addr`<=target, FETCH. !stall → IF/ID <= skid (valid 1, pc4 = pc+4), FETCH. stall → stay.
- State KILL (request held at old address): redirect → `kill_target`<=new target (latest wins). ack → response discarded, `req_addr`<=`kill_target` (or redirect target if same cycle), FETCH. `if_id_valid` remains 0.
- Address arithmetic modulo 2^ADDR_W (0xFFFFFFFC+4 = 0). Targets used unmodified; low bits unchecked.

## Timing
- Reset (`rst_n`=0 at edge): state FETCH, `req_addr`=RESET_PC, `if_id_valid`=0, `if_id_instr`/`if_id_pc`/`if_id_pc4`=0, skid and `kill_target`=0; `imem_req`=0 while `rst_n` low; `imem_addr`=RESET_PC.
- First request in the cycle `rst_n` is high. Reset mid-KILL/HOLD aborts everything; in-flight response ignored.
- Latency: ack in cycle N → IF/ID valid at N+1. Zero-latency memory sustains one instruction per cycle.
- Redirect in cycle N → `if_id_valid`=0 at N+1; target on `imem_addr` at N+1 (FETCH with ack, or HOLD) or cycle after the old request's ack (KILL).
- `imem_addr` never changes while `imem_req` high without ack.

## Test plan
- Reset, zero-latency ack every cycle → `imem_addr` 0,4,8 on consecutive cycles; `if_id_pc` 0,4,8 one cycle later, `if_id_pc4` 4,8,12.
- `sel_valid`=1, sel=01, `jump_target`=0x100 during acked fetch of 0x8 → `if_id_valid`=0 next cycle, `imem_addr`=0x100, then `if_id_pc`=0x100.
- 3-cycle memory, sel=11, `branch_target`=0x40 while 0x8 outstanding → `imem_addr` stays 0x8 until ack, data discarded, next request 0x40; second redirect to 0x80 in KILL → 0x80 fetched instead.
- `stall` high when 0xC acked → IF/ID keeps 0x8, `imem_req`=0; release → `if_id_pc`=0xC next cycle, request 0x10.
- sel=10 or sel=11 with `sel_valid`=0 → sequential fetch continues; `req_addr`=0xFFFFFFFC acked → next 0x0.
- `rst_n` low during KILL → next cycle `imem_addr`=RESET_PC, `if_id_valid`=0, late ack ignored.
